// File: rtl/edm_obi_sbr_if.sv
// rtl/edm_obi_sbr_if.sv - OBI request/response signal bundle for the EDM Sobel subordinate
interface edm_obi_sbr_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
    logic        rvalid;
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
    logic        r_optional;

    modport master (
        output req, addr, we, be, wdata, aid,
        input  gnt, rvalid, rdata, rid, err, r_optional
    );
    modport slave (
        input  req, addr, we, be, wdata, aid,
        output gnt, rvalid, rdata, rid, err, r_optional
    );
endinterface

// File: rtl/edm_obi_sbr.sv
// rtl/edm_obi_sbr.sv - Sobel 3x3 edge accelerator on OBI; EDM_SATURATE_EN clamps stored magnitude to 255
module edm_obi_sbr #(
    parameter int FifoDepth = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    edm_obi_sbr_if.slave  obi
);
    localparam int AW = $clog2(FifoDepth);
    localparam logic [AW:0] DEPTH = FifoDepth[AW:0];

    logic [23:0]   r_row0, r_row1, r_row2;
    logic          r_s1_valid, r_s2_valid;
    logic [10:0]   r_gx, r_gy, r_mag;
    logic [10:0]   r_mem [FifoDepth];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic          r_rvalid, r_err;
    logic [31:0]   r_rdata;
    logic [3:0]    r_rid;

    logic          w_addr_ok, w_wr, w_rd, w_launch, w_full, w_busy;
    logic          w_pop, w_flush, w_push, w_drop;
    logic [2:0]    w_off;
    logic [23:0]   w_row2_new;
    logic [9:0]    w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
    logic [10:0]   w_abs_x, w_abs_y, w_mag, w_mag_st;
    logic [31:0]   w_rdata;
    logic          w_err;
    logic          w_unused;

    function automatic logic [23:0] f_merge(input logic [23:0] old_row,
                                            input logic [31:0] wd,
                                            input logic [3:0]  be);
        logic [23:0] m;
        m = old_row;
        for (int i = 0; i < 3; i++) begin
            if (be[i]) m[8*i +: 8] = wd[8*i +: 8];
        end
        return m;
    endfunction

    assign w_unused  = ^{obi.addr[1:0], obi.be[3], obi.wdata[31:24]};
    assign w_off     = obi.addr[4:2];
    assign w_addr_ok = (obi.addr[31:5] == 27'd0) && (w_off < 3'd6);
    assign w_wr      = obi.req && obi.we && w_addr_ok;
    assign w_rd      = obi.req && !obi.we && w_addr_ok;
    assign w_launch  = w_wr && (w_off == 3'd2);

    // The launched window uses this cycle's ROW2 bytes, not the stale register
    assign w_row2_new = f_merge(r_row2, obi.wdata, obi.be);

    assign w_gx_pos = {2'b0, r_row0[23:16]} + {1'b0, r_row1[23:16], 1'b0} + {2'b0, w_row2_new[23:16]};
    assign w_gx_neg = {2'b0, r_row0[7:0]}   + {1'b0, r_row1[7:0], 1'b0}   + {2'b0, w_row2_new[7:0]};
    assign w_gy_pos = {2'b0, w_row2_new[7:0]} + {1'b0, w_row2_new[15:8], 1'b0} + {2'b0, w_row2_new[23:16]};
    assign w_gy_neg = {2'b0, r_row0[7:0]}     + {1'b0, r_row0[15:8], 1'b0}     + {2'b0, r_row0[23:16]};

    assign w_abs_x = r_gx[10] ? (~r_gx + 11'd1) : r_gx;
    assign w_abs_y = r_gy[10] ? (~r_gy + 11'd1) : r_gy;
    assign w_mag   = w_abs_x + w_abs_y;
`ifdef EDM_SATURATE_EN
    assign w_mag_st = (w_mag > 11'd255) ? 11'd255 : w_mag;
`else
    assign w_mag_st = w_mag;
`endif

    assign w_full  = (r_count == DEPTH);
    assign w_busy  = r_s1_valid || r_s2_valid;
    assign w_pop   = w_rd && (w_off == 3'd3) && (r_count != '0);
    assign w_flush = w_wr && (w_off == 3'd5) && obi.be[0] && obi.wdata[0];
    // A pop in the same cycle frees the slot a push into a full FIFO needs
    assign w_push  = r_s2_valid && !w_flush && (!w_full || w_pop);
    assign w_drop  = r_s2_valid && !w_flush && w_full && !w_pop;

    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        if (!w_addr_ok) begin
            w_err = 1'b1;
        end else if (!obi.we) begin
            case (w_off)
                3'd3: if (r_count != '0) w_rdata = {1'b1, 20'd0, r_mem[r_rptr]};
                3'd4: w_rdata = {15'd0, w_busy, 6'd0, r_ovf, w_full, 4'd0, 4'(r_count)};
                default: w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_row0     <= '0;
            r_row1     <= '0;
            r_row2     <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_gx       <= '0;
            r_gy       <= '0;
            r_mag      <= '0;
        end else begin
            if (w_wr && w_off == 3'd0) r_row0 <= f_merge(r_row0, obi.wdata, obi.be);
            if (w_wr && w_off == 3'd1) r_row1 <= f_merge(r_row1, obi.wdata, obi.be);
            if (w_launch) begin
                r_row2 <= w_row2_new;
                r_gx   <= {1'b0, w_gx_pos} - {1'b0, w_gx_neg};
                r_gy   <= {1'b0, w_gy_pos} - {1'b0, w_gy_neg};
            end
            r_s1_valid <= w_launch;
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) r_mag <= w_mag_st;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= r_mag;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rid    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= obi.req;
            r_rdata  <= obi.req ? w_rdata : '0;
            r_err    <= obi.req && w_err;
            if (obi.req) r_rid <= obi.aid;
        end
    end

    assign obi.gnt        = 1'b1;
    assign obi.rvalid     = r_rvalid;
    assign obi.rdata      = r_rdata;
    assign obi.rid        = r_rid;
    assign obi.err        = r_err;
    assign obi.r_optional = 1'b0;
endmodule

// File: tb/tb_edm_obi_sbr.sv
// tb/tb_edm_obi_sbr.sv - self-checking bench for edm_obi_sbr, follows EDM_SATURATE_EN
module tb_edm_obi_sbr;
    localparam int DEPTH = 4;
`ifdef EDM_SATURATE_EN
    localparam logic [31:0] RES_1020 = 32'h800000FF;
    localparam logic [31:0] RES_1530 = 32'h800000FF;
`else
    localparam logic [31:0] RES_1020 = 32'h800003FC;
    localparam logic [31:0] RES_1530 = 32'h800005FA;
`endif

    typedef struct {
        bit          req;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [3:0]  aid;
        bit          chk;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    edm_obi_sbr_if obi_if ();
    edm_obi_sbr #(.FifoDepth(DEPTH)) dut (.clk_i(clk_i), .rst_i(rst_i), .obi(obi_if));

    int n_checks = 0;
    int n_errors = 0;

    int m_px [9];
    int m_fifo [$];
    int m_pend_due [$];
    int m_pend_mag [$];
    bit m_ovf;
    int m_cyc = 0;

    logic [31:0] e_rdata;
    bit          e_err;
    logic        a_rvalid, a_err;
    logic [31:0] a_rdata;
    logic [3:0]  a_rid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sobel();
        int gx, gy, mag;
        gx  = (m_px[2] + 2*m_px[5] + m_px[8]) - (m_px[0] + 2*m_px[3] + m_px[6]);
        gy  = (m_px[6] + 2*m_px[7] + m_px[8]) - (m_px[0] + 2*m_px[1] + m_px[2]);
        mag = iabs(gx) + iabs(gy);
`ifdef EDM_SATURATE_EN
        if (mag > 255) mag = 255;
`endif
        return mag;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_px[i] = 0;
        m_fifo.delete();
        m_pend_due.delete();
        m_pend_mag.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_expect(input bit req, input bit we, input logic [31:0] addr);
        e_rdata = '0;
        e_err   = 1'b0;
        if (req && addr >= 32'h18) begin
            e_err = 1'b1;
        end else if (req && !we && addr == 32'h0C && m_fifo.size() > 0) begin
            e_rdata = 32'h8000_0000 | 32'(m_fifo[0]);
        end else if (req && !we && addr == 32'h10) begin
            e_rdata[3:0] = 4'(m_fifo.size());
            e_rdata[8]   = (m_fifo.size() == DEPTH);
            e_rdata[9]   = m_ovf;
            e_rdata[16]  = (m_pend_due.size() != 0);
        end
    endtask

    task automatic model_edge(input bit req, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
        bit pop, flush;
        int mag, r;
        pop   = req && !we && addr == 32'h0C && m_fifo.size() > 0;
        flush = req && we && addr == 32'h14 && be[0] && wdata[0];
        if (pop) void'(m_fifo.pop_front());
        if (m_pend_due.size() > 0 && m_pend_due[0] == m_cyc) begin
            void'(m_pend_due.pop_front());
            mag = m_pend_mag.pop_front();
            if (!flush) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(mag);
                else m_ovf = 1'b1;
            end
        end
        if (flush) begin
            m_fifo.delete();
            m_ovf = 1'b0;
        end
        if (req && we && addr < 32'h0C) begin
            r = int'(addr[3:2]);
            for (int c = 0; c < 3; c++) if (be[c]) m_px[r*3 + c] = int'(wdata[8*c +: 8]);
            if (r == 2) begin
                m_pend_due.push_back(m_cyc + 2);
                m_pend_mag.push_back(sobel());
            end
        end
        m_cyc++;
    endtask

    task automatic cycle(input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input logic [3:0] aid);
        @(negedge clk_i);
        obi_if.req   = req;
        obi_if.we    = we;
        obi_if.addr  = addr;
        obi_if.wdata = wdata;
        obi_if.be    = be;
        obi_if.aid   = aid;
        model_expect(req, we, addr);
        @(posedge clk_i);
        #1;
        model_edge(req, we, addr, wdata, be);
        a_rvalid = obi_if.rvalid;
        a_rdata  = obi_if.rdata;
        a_rid    = obi_if.rid;
        a_err    = obi_if.err;
        obi_if.req = 1'b0;
    endtask

    function automatic vec_t vwb(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        vec_t v;
        v = '{req: 1'b1, we: 1'b1, addr: addr, wdata: wdata, be: be, aid: 4'h0,
              chk: 1'b1, exp_rdata: 32'h0, exp_err: 1'b0};
        return v;
    endfunction

    function automatic vec_t vw(input logic [31:0] addr, input logic [31:0] wdata);
        return vwb(addr, wdata, 4'hF);
    endfunction

    function automatic vec_t vr(input logic [31:0] addr, input logic [31:0] exp,
                                input logic [3:0] aid, input bit err);
        vec_t v;
        v = '{req: 1'b1, we: 1'b0, addr: addr, wdata: 32'h0, be: 4'hF, aid: aid,
              chk: 1'b1, exp_rdata: exp, exp_err: err};
        return v;
    endfunction

    function automatic vec_t vi();
        vec_t v;
        v = '{req: 1'b0, we: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'h0, aid: 4'h0,
              chk: 1'b0, exp_rdata: 32'h0, exp_err: 1'b0};
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [$];
        obi_if.req = 1'b0; obi_if.we = 1'b0; obi_if.addr = '0;
        obi_if.wdata = '0; obi_if.be = '0; obi_if.aid = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_rvalid", 32'(obi_if.rvalid), 32'h0);
        check("rst_rdata",  obi_if.rdata,       32'h0);
        check("rst_rid",    32'(obi_if.rid),    32'h0);
        check("rst_err",    32'(obi_if.err),    32'h0);
        check("rst_gnt",    32'(obi_if.gnt),    32'h1);
        @(negedge clk_i);
        rst_i = 1'b0;

        // horizontal edge
        tbl.push_back(vw(32'h00, 32'h000000)); tbl.push_back(vw(32'h04, 32'h000000));
        tbl.push_back(vw(32'h08, 32'hFFFFFF)); tbl.push_back(vi()); tbl.push_back(vi());
        tbl.push_back(vr(32'h0C, RES_1020, 4'h0, 1'b0));
        // vertical edge, then empty reads
        tbl.push_back(vw(32'h00, 32'hFF0000)); tbl.push_back(vw(32'h04, 32'hFF0000));
        tbl.push_back(vw(32'h08, 32'hFF0000)); tbl.push_back(vi()); tbl.push_back(vi());
        tbl.push_back(vr(32'h0C, RES_1020, 4'h0, 1'b0));
        tbl.push_back(vr(32'h0C, 32'h0, 4'h0, 1'b0));
        tbl.push_back(vr(32'h10, 32'h0, 4'h0, 1'b0));
        // diagonal
        tbl.push_back(vw(32'h08, 32'hFFFFFF)); tbl.push_back(vi()); tbl.push_back(vi());
        tbl.push_back(vr(32'h0C, RES_1530, 4'h0, 1'b0));
        // RESULT read coinciding with push into an empty FIFO
        tbl.push_back(vw(32'h08, 32'hFFFFFF)); tbl.push_back(vi());
        tbl.push_back(vr(32'h0C, 32'h0, 4'h0, 1'b0));
        tbl.push_back(vr(32'h0C, RES_1530, 4'h0, 1'b0));
        tbl.push_back(vr(32'h10, 32'h0, 4'h0, 1'b0));
        // flush coinciding with push
        tbl.push_back(vw(32'h08, 32'hFFFFFF)); tbl.push_back(vi());
        tbl.push_back(vw(32'h14, 32'h1));
        tbl.push_back(vr(32'h10, 32'h0, 4'h0, 1'b0));
        // overflow
        for (int i = 0; i < 5; i++) tbl.push_back(vw(32'h08, 32'hFFFFFF));
        tbl.push_back(vi()); tbl.push_back(vi());
        tbl.push_back(vr(32'h10, 32'h304, 4'h0, 1'b0));
        tbl.push_back(vw(32'h14, 32'h1));
        tbl.push_back(vr(32'h10, 32'h0, 4'h0, 1'b0));
        // bus protocol and address errors
        tbl.push_back(vr(32'h10, 32'h0, 4'h1, 1'b0));
        tbl.push_back(vr(32'h10, 32'h0, 4'h2, 1'b0));
        tbl.push_back(vr(32'h10, 32'h0, 4'h3, 1'b0));
        tbl.push_back(vr(32'h00, 32'h0, 4'h4, 1'b0));
        tbl.push_back(vr(32'h14, 32'h0, 4'h5, 1'b0));
        tbl.push_back(vw(32'h0C, 32'h5)); tbl.push_back(vw(32'h10, 32'h5));
        tbl.push_back(vr(32'h10, 32'h0, 4'h6, 1'b0));
        tbl.push_back(vr(32'h20, 32'h0, 4'h7, 1'b1));
        tbl.push_back(vr(32'h18, 32'h0, 4'h8, 1'b1));
        // busy window
        tbl.push_back(vw(32'h08, 32'h000000));
        tbl.push_back(vr(32'h10, 32'h10000, 4'h0, 1'b0));
        tbl.push_back(vr(32'h10, 32'h10000, 4'h0, 1'b0));
        tbl.push_back(vr(32'h10, 32'h1, 4'h0, 1'b0));
        tbl.push_back(vr(32'h0C, RES_1020, 4'h0, 1'b0));
        // partial byte enables on ROW2
        tbl.push_back(vwb(32'h08, 32'hFFFFFFFF, 4'b0100)); tbl.push_back(vi()); tbl.push_back(vi());
        tbl.push_back(vr(32'h0C, RES_1020, 4'h0, 1'b0));

        foreach (tbl[i]) begin
            cycle(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].aid);
            check($sformatf("tbl%0d_rvalid", i), 32'(a_rvalid), 32'(tbl[i].req));
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d_rdata", i), a_rdata, tbl[i].exp_rdata);
                check($sformatf("tbl%0d_err", i), 32'(a_err), 32'(tbl[i].exp_err));
                check($sformatf("tbl%0d_rid", i), 32'(a_rid), 32'(tbl[i].aid));
            end
        end

        // reset during T+1 of a launch
        cycle(1'b1, 1'b1, 32'h08, 32'hFFFFFF, 4'hF, 4'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("midrst_rvalid", 32'(obi_if.rvalid), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
        cycle(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 4'h9);
        check("midrst_status", a_rdata, 32'h0);
        cycle(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, 4'hA);
        check("midrst_result", a_rdata, 32'h0);

        for (int i = 0; i < 600; i++) begin
            int k;
            bit req, we;
            logic [31:0] addr, wdata;
            logic [3:0] be, aid;
            k = $urandom_range(0, 9);
            req = 1'b1; we = 1'b0; addr = 32'h0;
            wdata = $urandom; be = 4'($urandom); aid = 4'($urandom);
            case (k)
                0, 1:    req = 1'b0;
                2, 3, 4: begin we = 1'b1; addr = 32'($urandom_range(0, 2)) << 2; end
                5, 6:    addr = 32'h0C;
                7:       addr = 32'h10;
                8:       begin we = 1'b1; addr = 32'h14; wdata = ($urandom_range(0, 3) == 0) ? 32'h1 : 32'h0; end
                default: begin we = 1'($urandom_range(0, 1)); addr = 32'($urandom_range(0, 15)) << 2; end
            endcase
            cycle(req, we, addr, wdata, be, aid);
            check($sformatf("rnd%0d_rvalid", i), 32'(a_rvalid), 32'(req));
            if (req) begin
                check($sformatf("rnd%0d_rdata a=%h", i, addr), a_rdata, e_rdata);
                check($sformatf("rnd%0d_err", i), 32'(a_err), 32'(e_err));
                check($sformatf("rnd%0d_rid", i), 32'(a_rid), 32'(aid));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
